// File: rtl/clk_div_pkg.sv
// Shared defaults and per-channel state type for the multi-channel clock divider.
// Channel state is held at the full default width; narrower builds zero-extend into it.
package clk_div_pkg;

  localparam int unsigned CNT_W_DEF   = 32;
  localparam int unsigned DEF_DIV_DEF = 100_000_000;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  typedef struct packed {
    cnt_t cnt;
    cnt_t div_act;
    cnt_t div_shd;
  } ch_state_t;

  // Terminal count of a running channel; the >= keeps a shrunken div_act from wrapping.
  function automatic logic is_terminal(input cnt_t cnt, input cnt_t div_act);
    return (div_act != '0) && (cnt >= (div_act - cnt_t'(1)));
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active/shadow half-period and registered slowclk/tick.
// Build option MULTI_CLK_DIV_IMMEDIATE_EN: writes load div_act directly and restart the phase.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DEF_DIV = DEF_DIV_DEF
) (
  input  logic             i_fastclk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_div,
  output logic             o_slowclk,
  output logic             o_tick
);

  localparam cnt_t CNT_MASK = cnt_t'('1) >> (CNT_W_DEF - CNT_W);
  localparam cnt_t DIV_RST  = cnt_t'(DEF_DIV) & CNT_MASK;

  ch_state_t r_st;
  ch_state_t w_st_d;
  logic      r_slowclk;
  logic      w_slowclk_d;
  logic      r_tick;
  logic      w_tick_d;
  cnt_t      w_wr_div;

  assign w_wr_div = cnt_t'(i_wr_div);

  always_comb begin
    w_st_d      = r_st;
    w_slowclk_d = r_slowclk;
    w_tick_d    = 1'b0;
    if (!i_en || (r_st.div_act == '0)) begin
      // Nothing in flight while stopped, so a new half-period can apply at once.
      w_st_d.cnt     = '0;
      w_st_d.div_act = i_wr ? w_wr_div : r_st.div_shd;
      if (!i_en) begin
        w_slowclk_d = 1'b0;
      end
    end else if (is_terminal(r_st.cnt, r_st.div_act)) begin
      w_st_d.cnt     = '0;
      w_st_d.div_act = r_st.div_shd;
      w_slowclk_d    = ~r_slowclk;
      w_tick_d       = 1'b1;
    end else begin
      w_st_d.cnt = r_st.cnt + cnt_t'(1);
    end

    if (i_wr) begin
      w_st_d.div_shd = w_wr_div;
`ifdef MULTI_CLK_DIV_IMMEDIATE_EN
      w_st_d.div_act = w_wr_div;
      w_st_d.cnt     = '0;
      w_slowclk_d    = 1'b0;
      w_tick_d       = 1'b0;
`endif
    end
  end

  always_ff @(posedge i_fastclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st      <= '{cnt: '0, div_act: DIV_RST, div_shd: DIV_RST};
      r_slowclk <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_st      <= w_st_d;
      r_slowclk <= w_slowclk_d;
      r_tick    <= w_tick_d;
    end
  end

  assign o_slowclk = r_slowclk;
  assign o_tick    = r_tick;

endmodule

// File: rtl/multi_clk_div.sv
// NUM_CH independent fastclk dividers sharing one divide-value write port.
// Build option MULTI_CLK_DIV_IMMEDIATE_EN selects phase-restarting writes; ports are identical.
module multi_clk_div
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DEF_DIV = DEF_DIV_DEF,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_fastclk,
  input  logic              i_rst_n,
  input  logic [NUM_CH-1:0] i_ch_en,
  input  logic              i_wr_en,
  input  logic [CH_W-1:0]   i_wr_ch,
  input  logic [CNT_W-1:0]  i_wr_div,
  output logic [NUM_CH-1:0] o_slowclk,
  output logic [NUM_CH-1:0] o_tick
);

  logic              w_wr_ok;
  logic [NUM_CH-1:0] w_wr_hit;

  // Out-of-range channel numbers are dropped rather than aliased.
  assign w_wr_ok = i_wr_en && ({1'b0, i_wr_ch} < (CH_W + 1)'(NUM_CH));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr_hit[g] = w_wr_ok && (i_wr_ch == CH_W'(g));

    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .i_fastclk (i_fastclk),
      .i_rst_n   (i_rst_n),
      .i_en      (i_ch_en[g]),
      .i_wr      (w_wr_hit[g]),
      .i_wr_div  (i_wr_div),
      .o_slowclk (o_slowclk[g]),
      .o_tick    (o_tick[g])
    );
  end

endmodule

// File: tb/tb_multi_clk_div.sv
// Directed bench for multi_clk_div: a 4-channel and a 3-channel instance, both DEF_DIV=5.
module tb_multi_clk_div;

  logic        clk;
  logic        rst_n;
  logic [3:0]  ch_en;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [15:0] wr_div;
  logic [3:0]  slowclk;
  logic [3:0]  tick;

  logic [2:0]  b_ch_en;
  logic        b_wr_en;
  logic [1:0]  b_wr_ch;
  logic [15:0] b_wr_div;
  logic [2:0]  b_slowclk;
  logic [2:0]  b_tick;

  int n_total = 0;
  int n_bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  multi_clk_div #(.NUM_CH(4), .CNT_W(16), .DEF_DIV(5)) u_dut (
    .i_fastclk (clk),
    .i_rst_n   (rst_n),
    .i_ch_en   (ch_en),
    .i_wr_en   (wr_en),
    .i_wr_ch   (wr_ch),
    .i_wr_div  (wr_div),
    .o_slowclk (slowclk),
    .o_tick    (tick)
  );

  multi_clk_div #(.NUM_CH(3), .CNT_W(16), .DEF_DIV(5)) u_dut_b (
    .i_fastclk (clk),
    .i_rst_n   (rst_n),
    .i_ch_en   (b_ch_en),
    .i_wr_en   (b_wr_en),
    .i_wr_ch   (b_wr_ch),
    .i_wr_div  (b_wr_div),
    .o_slowclk (b_slowclk),
    .o_tick    (b_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic write_a(input logic [1:0] ch, input logic [15:0] d);
    wr_ch  = ch;
    wr_div = d;
    wr_en  = 1'b1;
    @(negedge clk);
    wr_en  = 1'b0;
  endtask

  initial begin
    logic lvl;
    logic tog;
    logic frozen;

    rst_n = 1'b0; ch_en = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    b_ch_en = '0; b_wr_en = 1'b0; b_wr_ch = '0; b_wr_div = '0;
    repeat (2) @(negedge clk);
    check("rst_slow", 32'(slowclk), 32'(0));
    check("rst_tick", 32'(tick), 32'(0));
    check("rst_b_slow", 32'(b_slowclk), 32'(0));
    check("rst_b_tick", 32'(b_tick), 32'(0));

    // Default half-period 5 on channel 0 only.
    rst_n = 1'b1;
    ch_en = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check("def_slow", 32'(slowclk), 32'({3'b000, ((k / 5) % 2) == 1}));
      check("def_tick", 32'(tick), 32'({3'b000, (k % 5) == 0}));
    end
    ch_en = '0;
    @(negedge clk);

    // Channel 1: div 8 running, write 3 mid-period.
    write_a(2'd1, 16'd8);
    wr_ch = 2'd1; wr_div = 16'd3;
    ch_en = 4'b0010;
    lvl   = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      wr_en = (k == 3);
`ifdef MULTI_CLK_DIV_IMMEDIATE_EN
      if (k == 4) lvl = 1'b0;
      tog = (k >= 7) && (((k - 7) % 3) == 0);
`else
      tog = (k == 8) || ((k > 8) && (((k - 8) % 3) == 0));
`endif
      lvl = lvl ^ tog;
      check("shd_slow", 32'(slowclk[1]), 32'(lvl));
      check("shd_tick", 32'(tick[1]), 32'(tog));
    end
    wr_en = 1'b0;
    ch_en = '0;
    @(negedge clk);

    // Channel 3: div 1 toggles every cycle, then div 0 freezes.
    write_a(2'd3, 16'd1);
    ch_en = 4'b1000;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("div1_slow", 32'(slowclk[3]), 32'(k % 2));
      check("div1_tick", 32'(tick[3]), 32'(1));
    end
    wr_ch = 2'd3; wr_div = 16'd0; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
`ifdef MULTI_CLK_DIV_IMMEDIATE_EN
    frozen = 1'b0;
`else
    frozen = 1'b1;
`endif
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("div0_slow", 32'(slowclk[3]), 32'(frozen));
      check("div0_tick", 32'(tick[3]), 32'(0));
    end
    ch_en = '0;
    @(negedge clk);

    // Channel 2: div 10, disable at counter 4, re-enable, then write on a terminal count.
    write_a(2'd2, 16'd10);
    ch_en = 4'b0100;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check("en_slow", 32'(slowclk[2]), 32'(k >= 10));
      check("en_tick", 32'(tick[2]), 32'(k == 10));
    end
    ch_en = '0;
    @(negedge clk);
    check("dis_slow", 32'(slowclk[2]), 32'(0));
    check("dis_tick", 32'(tick[2]), 32'(0));
    @(negedge clk);
    wr_ch = 2'd2; wr_div = 16'd4;
    ch_en = 4'b0100;
    lvl   = 1'b0;
    for (int j = 1; j <= 34; j++) begin
      @(negedge clk);
      wr_en = (j == 19);
`ifdef MULTI_CLK_DIV_IMMEDIATE_EN
      if (j == 20) lvl = 1'b0;
      tog = (j == 10) || (j == 24) || (j == 28) || (j == 32);
`else
      tog = (j == 10) || (j == 20) || (j == 30) || (j == 34);
`endif
      lvl = lvl ^ tog;
      check("reen_slow", 32'(slowclk[2]), 32'(lvl));
      check("reen_tick", 32'(tick[2]), 32'(tog));
    end
    wr_en = 1'b0;
    ch_en = '0;
    @(negedge clk);

    // Asynchronous reset between edges while channels are high.
    ch_en   = 4'b0001;
    b_ch_en = 3'b111;
    repeat (7) @(negedge clk);
    check("pre_rst_slow", 32'(slowclk), 32'(4'b0001));
    check("pre_rst_b_slow", 32'(b_slowclk), 32'(3'b111));
    #2 rst_n = 1'b0;
    #1;
    check("arst_slow", 32'(slowclk), 32'(0));
    check("arst_tick", 32'(tick), 32'(0));
    check("arst_b_slow", 32'(b_slowclk), 32'(0));
    check("arst_b_tick", 32'(b_tick), 32'(0));
    @(negedge clk);

    // Release reset; out-of-range write on the 3-channel instance must be ignored.
    ch_en = '0; b_ch_en = '0;
    rst_n = 1'b1;
    b_wr_ch = 2'd3; b_wr_div = 16'd2; b_wr_en = 1'b1;
    @(negedge clk);
    b_wr_en = 1'b0;
    ch_en   = 4'b1111;
    b_ch_en = 3'b111;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check("post_rst_slow", 32'(slowclk), 32'((k >= 5) ? 4'b1111 : 4'b0000));
      check("post_rst_tick", 32'(tick), 32'((k == 5) ? 4'b1111 : 4'b0000));
      check("oor_b_slow", 32'(b_slowclk), 32'((k >= 5) ? 3'b111 : 3'b000));
      check("oor_b_tick", 32'(b_tick), 32'((k == 5) ? 3'b111 : 3'b000));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
